// File: rtl/sdram_pkg.sv
// sdram_pkg: arbiter state type and refresh-interval
// arithmetic shared by the SDRAM controller blocks.
package sdram_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    REF,
    USER
  } arb_state_t;

  function automatic int ref_cycle(
    input int ns,
    input int mhz
  );
    return ns * mhz / 1000;
  endfunction

endpackage

// File: rtl/sdram_inc.svh
// sdram_inc: SDRAM command-type encodings shared by the
// arbiter, init sequencer and command executor.
`ifndef SDRAM_INC_SVH
`define SDRAM_INC_SVH
`define CMD_NOP       4'h0
`define CMD_ACTIVE    4'h1
`define CMD_READ      4'h2
`define CMD_WRITE     4'h3
`define CMD_PRECHARGE 4'h4
`define CMD_REFRESH   4'h5
`define CMD_MRS       4'h6
`endif

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer: tREFI countdown plus saturating
// pending-refresh counter with a completion decrement.
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter  int CYC  = 390,
  parameter  int MAXP = 4,
  localparam int TW   = $clog2(CYC),
  localparam int PW   = $clog2(MAXP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          dec_i,
  output logic [PW-1:0] pend_o
);

  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          tick;
  logic          inc;
  logic          dec;

  assign tick = en_i && (timer_q == '0);

  // a tick and a completion together cancel out
  assign inc = tick && !dec_i
            && (pend_q != PW'(MAXP));
  assign dec = dec_i && !tick
            && (pend_q != '0);

  always_comb begin
    timer_d = timer_q;
    if (tick)
      timer_d = TW'(CYC - 1);
    else if (en_i)
      timer_d = timer_q - TW'(1);
  end

  always_comb begin
    pend_d = pend_q;
    unique case (1'b1)
      inc:     pend_d = pend_q + PW'(1);
      dec:     pend_d = pend_q - PW'(1);
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= TW'(CYC - 1);
      pend_q  <= '0;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: owns the executor port for init, refresh, user.
// Option SDRAM_REF_POSTPONE_EN: user traffic defers refresh.
`include "sdram_inc.svh"
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter  int CLK_FREQ        = 50,
  parameter  int AW              = 12,
  parameter  int REF_INTERVAL_NS = 7812,
  parameter  int REF_MAX_PEND    = 4,
  localparam int PW = $clog2(REF_MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_valid,
  input  logic [3:0]    init_cmd,
  input  logic [AW-1:0] init_addr,
  input  logic          init_done,
  input  logic          user_valid,
  input  logic [3:0]    user_cmd,
  input  logic [AW-1:0] user_addr,
  input  logic          user_lock,
  output logic          user_ready,
  output logic          user_done,
  output logic          cmd_valid,
  output logic [3:0]    cmd_type,
  output logic [AW-1:0] cmd_addr,
  input  logic          cmd_ready,
  input  logic          cmd_done,
  output logic [PW-1:0] ref_pend
);

  localparam int REF_CYCLE =
    ref_cycle(REF_INTERVAL_NS, CLK_FREQ);

  arb_state_t state_q, state_d;
  logic       acc_q, acc_d;
  logic       ref_due;

  assign ref_due = (ref_pend != '0);

  sdram_ref_timer #(
    .CYC (REF_CYCLE),
    .MAXP(REF_MAX_PEND)
  ) u_ref (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q != INIT),
    .dec_i ((state_q == REF) && cmd_done),
    .pend_o(ref_pend)
  );

`ifdef SDRAM_REF_POSTPONE_EN
  logic pend_full;
  assign pend_full =
    (ref_pend == PW'(REF_MAX_PEND));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    unique case (state_q)
      INIT: if (init_done) state_d = IDLE;
      IDLE: begin
        // an open row blocks refresh entirely
        if (user_lock) begin
          if (user_valid) state_d = USER;
        end
`ifdef SDRAM_REF_POSTPONE_EN
        else if (pend_full) state_d = REF;
        else if (user_valid) state_d = USER;
        else if (ref_due) state_d = REF;
`else
        else if (ref_due) state_d = REF;
        else if (user_valid) state_d = USER;
`endif
      end
      REF, USER: begin
        if (cmd_done) begin
          state_d = IDLE;
          acc_d   = 1'b0;
        end else if (cmd_valid && cmd_ready) begin
          acc_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    cmd_valid  = 1'b0;
    cmd_type   = `CMD_NOP;
    cmd_addr   = '0;
    user_ready = 1'b0;
    user_done  = 1'b0;
    unique case (state_q)
      INIT: begin
        cmd_valid = init_valid;
        cmd_type  = init_cmd;
        cmd_addr  = init_addr;
      end
      IDLE: ;
      REF: begin
        cmd_valid = !acc_q;
        cmd_type  = `CMD_REFRESH;
      end
      USER: begin
        cmd_valid  = user_valid && !acc_q;
        cmd_type   = user_cmd;
        cmd_addr   = user_addr;
        user_ready = cmd_valid && cmd_ready;
        user_done  = cmd_done;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed stimulus with a command scoreboard
// and a behavioural executor driving cmd_ready/cmd_done.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  localparam int AW = 12;
  localparam int RC = 390;
  localparam logic [3:0] C_NOP = 4'h0;
  localparam logic [3:0] C_ACT = 4'h1;
  localparam logic [3:0] C_RD  = 4'h2;
  localparam logic [3:0] C_PRE = 4'h4;
  localparam logic [3:0] C_REF = 4'h5;
  localparam logic [3:0] C_MRS = 4'h6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_valid, init_done;
  logic [3:0]    init_cmd;
  logic [AW-1:0] init_addr;
  logic          user_valid, user_lock;
  logic [3:0]    user_cmd;
  logic [AW-1:0] user_addr;
  logic          user_ready, user_done;
  logic          cmd_valid;
  logic [3:0]    cmd_type;
  logic [AW-1:0] cmd_addr;
  logic          cmd_ready, cmd_done;
  logic [2:0]    ref_pend;

  sdram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_valid(init_valid),
    .init_cmd  (init_cmd),
    .init_addr (init_addr),
    .init_done (init_done),
    .user_valid(user_valid),
    .user_cmd  (user_cmd),
    .user_addr (user_addr),
    .user_lock (user_lock),
    .user_ready(user_ready),
    .user_done (user_done),
    .cmd_valid (cmd_valid),
    .cmd_type  (cmd_type),
    .cmd_addr  (cmd_addr),
    .cmd_ready (cmd_ready),
    .cmd_done  (cmd_done),
    .ref_pend  (ref_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    t;
    logic [AW-1:0] a;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   c0 = 0;
  int   ref_hs = 0;
  int   done_dly = 5;
  int   ex_cnt = 0;
  bit   ex_flush = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  int n, k, h, rdy, dn, t_acc, t_done, bad, hs0;

  initial begin
    rst_n = 1'b0;
    init_valid = 0; init_done = 0;
    init_cmd = C_NOP; init_addr = '0;
    user_valid = 0; user_lock = 0;
    user_cmd = C_NOP; user_addr = '0;
    cmd_ready = 0; cmd_done = 0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          smp();
          if (cmd_valid && cmd_ready) begin
            if (cmd_type == C_REF) ref_hs++;
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_cmd actual=%0h/%0h required=none",
                       cmd_type, cmd_addr);
            end else begin
              e = exp_q.pop_front();
              chk("sb_cmd_type", 32'(cmd_type), 32'(e.t));
              chk("sb_cmd_addr", 32'(cmd_addr), 32'(e.a));
            end
          end
        end
      end
      begin : executor
        forever begin
          @(negedge clk);
          cmd_done = 1'b0;
          if (ex_flush) begin
            ex_cnt = 0;
          end else if (ex_cnt > 0) begin
            ex_cnt--;
            if (ex_cnt == 0) cmd_done = 1'b1;
          end else if (cmd_valid && cmd_ready) begin
            ex_cnt = done_dly;
          end
        end
      end
      begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) step();
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_user_ready", 32'(user_ready), 0);
    chk("rst_user_done", 32'(user_done), 0);
    chk("rst_ref_pend", 32'(ref_pend), 0);

    // pass-through while uninitialised
    init_valid = 1; init_cmd = C_PRE;
    init_addr = 12'h400;
    user_valid = 1; user_cmd = C_ACT;
    rst_n = 1'b1;
    smp();
    chk("pt_valid", 32'(cmd_valid), 1);
    chk("pt_type", 32'(cmd_type), 32'(C_PRE));
    chk("pt_addr", 32'(cmd_addr), 32'h400);
    chk("pt_user_ready", 32'(user_ready), 0);
    exp_q.push_back('{C_PRE, 12'h400});
    step();
    cmd_ready = 1;
    step();
    cmd_ready = 0; init_valid = 0; user_valid = 0;
    repeat (10) step();
    cmd_ready = 1;
    chk("pt_drain", exp_q.size(), 0);

    // first refresh timing after init
    exp_q.push_back('{C_REF, 12'h000});
    done_dly = 5;
    init_done = 1;
    step();
    c0 = cyc;
    n = 0;
    while (!(cmd_valid && cmd_type == C_REF) && n < 600) begin
      step();
      n++;
    end
    chk("ref_first_latency", n, 391);
    chk("ref_pend_one", 32'(ref_pend), 1);
    n = 0;
    while (ref_pend != 0 && n < 30) begin
      step();
      n++;
    end
    chk("ref_done_latency", n, 6);
    chk("ref_pend_zero", 32'(ref_pend), 0);
    chk("idle_type_nop", 32'(cmd_type), 32'(C_NOP));

    // single user command
    done_dly = 3;
    exp_q.push_back('{C_ACT, 12'h123});
    user_cmd = C_ACT; user_addr = 12'h123;
    user_valid = 1;
    rdy = 0; dn = 0; t_acc = -1; t_done = -1; k = 0;
    while (!dn && k < 50) begin
      smp();
      if (user_ready) begin rdy++; t_acc = k; end
      if (user_done) begin dn = 1; t_done = k; end
      step();
      if (rdy > 0) user_valid = 0;
      k++;
    end
    chk("user_ready_pulses", rdy, 1);
    chk("user_done_seen", dn, 1);
    chk("user_done_lat", t_done - t_acc, 3);
    smp();
    chk("user_back_idle", 32'(cmd_valid), 0);
    chk("user_done_pulse", 32'(user_done), 0);

    // lock blocks refresh, counter saturates
    user_lock = 1;
    h = 0; bad = 0;
    while (h < 5 * RC || ((cyc - c0) % RC) != 2) begin
      step();
      h++;
      if (cmd_valid) bad++;
    end
    chk("lock_no_cmd", bad, 0);
    chk("lock_sat", 32'(ref_pend), 4);
    repeat (4) exp_q.push_back('{C_REF, 12'h000});
    done_dly = 2;
    hs0 = ref_hs;
    user_lock = 0;
    n = 0;
    while ((ref_pend != 0 || exp_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    chk("burst_ref_count", ref_hs - hs0, 4);
    chk("burst_pend_zero", 32'(ref_pend), 0);
    chk("burst_cycles", n, 16);

    // contention: pending refresh vs user
    n = 0;
    while (((cyc - c0) % RC) != 0 && n < 500) begin
      step();
      n++;
    end
    chk("cont_pend", 32'(ref_pend), 1);
`ifdef SDRAM_REF_POSTPONE_EN
    exp_q.push_back('{C_RD, 12'h055});
    exp_q.push_back('{C_REF, 12'h000});
`else
    exp_q.push_back('{C_REF, 12'h000});
    exp_q.push_back('{C_RD, 12'h055});
`endif
    user_cmd = C_RD; user_addr = 12'h055;
    user_valid = 1;
    rdy = 0; dn = 0; k = 0;
    while (!(dn && ref_pend == 0 && exp_q.size() == 0) && k < 60) begin
      smp();
      if (user_done) dn = 1;
      if (user_ready) rdy++;
      step();
      if (rdy > 0) user_valid = 0;
      k++;
    end
    chk("cont_user_done", dn, 1);
    chk("cont_ready_once", rdy, 1);
    chk("cont_pend_zero", 32'(ref_pend), 0);
    chk("cont_drain", exp_q.size(), 0);

    // reset while a refresh is in flight
    n = 0;
    while (((cyc - c0) % RC) != 0 && n < 500) begin
      step();
      n++;
    end
    exp_q.push_back('{C_REF, 12'h000});
    done_dly = 20;
    n = 0;
    while (!(cmd_valid && cmd_type == C_REF) && n < 20) begin
      step();
      n++;
    end
    step();
    step();
    chk("mid_ref_accepted", 32'(cmd_valid), 0);
    chk("mid_ref_pend", 32'(ref_pend), 1);
    rst_n = 0; init_done = 0; ex_flush = 1;
    #1;
    chk("arst_pend", 32'(ref_pend), 0);
    chk("arst_valid", 32'(cmd_valid), 0);
    chk("arst_user_ready", 32'(user_ready), 0);
    step();
    step();
    ex_flush = 0;
    cmd_ready = 0;
    init_valid = 1; init_cmd = C_MRS;
    init_addr = 12'h022;
    rst_n = 1;
    smp();
    chk("post_rst_valid", 32'(cmd_valid), 1);
    chk("post_rst_type", 32'(cmd_type), 32'(C_MRS));
    chk("post_rst_addr", 32'(cmd_addr), 32'h022);
    init_valid = 0;
    repeat (400) step();
    chk("init_timer_held", 32'(ref_pend), 0);
    chk("init_quiet", 32'(cmd_valid), 0);
    chk("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
